// File: rtl/dma_tx_rq_arbiter_pkg.sv
// rtl/dma_tx_rq_arbiter_pkg.sv - shared types and helpers for the TX request arbiter
package dma_tx_arb_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } arb_state_e;

  // Low bit of channel idx inside a flattened bus of width-bit fields, channel 0 at the LSBs.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/dma_tx_rq_arbiter_if.sv
// rtl/dma_tx_rq_arbiter_if.sv - engine-side request and completion bundle
interface dma_tx_rq_arbiter_if #(
  parameter int LW = 16,
  parameter int BW = 29,
  parameter int NW = 15,
  parameter int TW = 6
);
  logic          m_rq_valid;
  logic          m_rq_ready;
  logic [LW-1:0] m_rq_loc_addr;
  logic [BW-1:0] m_rq_bus_addr;
  logic [NW-1:0] m_rq_length;
  logic [TW-1:0] m_rq_tag;

  logic          s_rc_valid;
  logic          s_rc_ready;
  logic [TW-1:0] s_rc_tag;

  modport master (
    output m_rq_valid, m_rq_loc_addr, m_rq_bus_addr, m_rq_length, m_rq_tag,
    input  m_rq_ready,
    input  s_rc_valid, s_rc_tag,
    output s_rc_ready
  );

  modport slave (
    input  m_rq_valid, m_rq_loc_addr, m_rq_bus_addr, m_rq_length, m_rq_tag,
    output m_rq_ready,
    output s_rc_valid, s_rc_tag,
    input  s_rc_ready
  );
endinterface

// File: rtl/dma_tx_rq_arbiter_rr_arbiter.sv
// rtl/dma_tx_rq_arbiter_rr_arbiter.sv - combinational round-robin pick starting at ptr_i
module rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int CH_BITS  = 2
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [CH_BITS-1:0]  ptr_i,
  output logic [CHANNELS-1:0] grant_o,
  output logic [CH_BITS-1:0]  idx_o,
  output logic                any_o
);

  logic [CH_BITS-1:0] cand;

  // CHANNELS is a power of two, so the CH_BITS-wide add wraps for free.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = ptr_i;
    for (int k = 0; k < CHANNELS; k++) begin
      cand = ptr_i + CH_BITS'(k);
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_tx_rq_arbiter.sv
// rtl/dma_tx_rq_arbiter.sv - shares the TX DMA request port between channels and routes completions back
module dma_tx_rq_arbiter
  import dma_tx_arb_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int CH_BITS         = 2,
  parameter int CH_TAG_BITS     = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int RAM_ADDR_WIDTH  = 18,
  parameter int BUS_ADDR_WIDTH  = 32,
  parameter int DATA_BITS       = 3,
  localparam int LW = RAM_ADDR_WIDTH + 1 - DATA_BITS,
  localparam int BW = BUS_ADDR_WIDTH - DATA_BITS,
  localparam int NW = RAM_ADDR_WIDTH - DATA_BITS,
  localparam int TW = CH_BITS + CH_TAG_BITS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            core_ready_i,
  input  logic [CHANNELS-1:0]             ch_enable_i,
  input  logic [CHANNELS-1:0]             s_rq_valid_i,
  output logic [CHANNELS-1:0]             s_rq_ready_o,
  input  logic [CHANNELS*LW-1:0]          s_rq_loc_addr_i,
  input  logic [CHANNELS*BW-1:0]          s_rq_bus_addr_i,
  input  logic [CHANNELS*NW-1:0]          s_rq_length_i,
  input  logic [CHANNELS*CH_TAG_BITS-1:0] s_rq_tag_i,
  dma_tx_rq_arbiter_if.master             eng,
  output logic [CHANNELS-1:0]             ch_rc_valid_o,
  input  logic [CHANNELS-1:0]             ch_rc_ready_i,
  output logic [CH_TAG_BITS-1:0]          ch_rc_tag_o,
  output logic [CHANNELS*CNT_W-1:0]       ch_outstanding_o,
  output logic                            err_underflow_o
);

  arb_state_e           state_q, state_d;
  logic [CH_BITS-1:0]   grant_q;
  logic [CH_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [LW-1:0]        loc_q;
  logic [BW-1:0]        bus_q;
  logic [NW-1:0]        len_q;
  logic [TW-1:0]        tag_q;
  logic [CNT_W-1:0]     cnt_q [CHANNELS];
  logic [CNT_W-1:0]     cnt_d [CHANNELS];
  logic                 err_q, err_d;

  logic [CHANNELS-1:0]    elig;
  logic [CHANNELS-1:0]    arb_grant;
  logic [CH_BITS-1:0]     arb_idx;
  logic                   arb_any;
  logic                   load;
  logic [LW-1:0]          loc_mux;
  logic [BW-1:0]          bus_mux;
  logic [NW-1:0]          len_mux;
  logic [CH_TAG_BITS-1:0] tag_mux;
  logic [CH_BITS-1:0]     rc_ch;
  logic [CHANNELS-1:0]    dec_vec;

  always_comb begin
    elig = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      elig[c] = s_rq_valid_i[c] && ch_enable_i[c] && (cnt_q[c] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .CH_BITS  (CH_BITS)
  ) u_rr (
    .req_i   (elig),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  always_comb begin
    loc_mux = '0;
    bus_mux = '0;
    len_mux = '0;
    tag_mux = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (arb_grant[c]) begin
        loc_mux = s_rq_loc_addr_i[slice_lo(c, LW) +: LW];
        bus_mux = s_rq_bus_addr_i[slice_lo(c, BW) +: BW];
        len_mux = s_rq_length_i[slice_lo(c, NW) +: NW];
        tag_mux = s_rq_tag_i[slice_lo(c, CH_TAG_BITS) +: CH_TAG_BITS];
      end
    end
  end

  // Fields are only sampled in IDLE, so a channel whose ready pulses in ACK cannot be granted twice.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (core_ready_i && arb_any) begin
          load    = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (eng.m_rq_ready) state_d = ST_ACK;
      end
      ST_ACK: begin
        rr_ptr_d = grant_q + CH_BITS'(1);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_rq_ready_o      = (state_q == ST_ACK) ? (CHANNELS'(1) << grant_q) : '0;
  assign eng.m_rq_valid    = (state_q == ST_ISSUE);
  assign eng.m_rq_loc_addr = loc_q;
  assign eng.m_rq_bus_addr = bus_q;
  assign eng.m_rq_length   = len_q;
  assign eng.m_rq_tag      = tag_q;

  // Completion router: purely combinational, the channel number rides in the tag MSBs.
  assign rc_ch          = eng.s_rc_tag[TW-1 -: CH_BITS];
  assign ch_rc_valid_o  = eng.s_rc_valid ? (CHANNELS'(1) << rc_ch) : '0;
  assign ch_rc_tag_o    = eng.s_rc_tag[CH_TAG_BITS-1:0];
  assign eng.s_rc_ready = ch_rc_ready_i[rc_ch];
  assign dec_vec        = ch_rc_valid_o & {CHANNELS{eng.s_rc_ready}};

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (s_rq_ready_o[c] && !dec_vec[c]) begin
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
      end else if (dec_vec[c] && !s_rq_ready_o[c]) begin
        if (cnt_q[c] == '0) err_d = 1'b1;
        else                cnt_d[c] = cnt_q[c] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      loc_q    <= '0;
      bus_q    <= '0;
      len_q    <= '0;
      tag_q    <= '0;
      err_q    <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      if (load) begin
        grant_q <= arb_idx;
        loc_q   <= loc_mux;
        bus_q   <= bus_mux;
        len_q   <= len_mux;
        tag_q   <= {arb_idx, tag_mux};
      end
    end
  end

  always_comb begin
    ch_outstanding_o = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ch_outstanding_o[slice_lo(c, CNT_W) +: CNT_W] = cnt_q[c];
    end
  end

  assign err_underflow_o = err_q;

endmodule
